audio_pwm_mc: RTL and testbench

Multi-channel audio DAC front end: converts CHANNELS parallel WIDTH-bit unsigned samples into 1-bit outputs, one per channel.
- Two modes: edge-aligned PWM, or first-order delta-sigma.
- Samples arrive over a valid/ready handshake into a one-frame holding buffer and are applied at frame boundaries.
- Sits between the sound mixer and the board audio pins. Successor to the single-channel 8-bit PWM output.

---
 rtl/audio_pkg.sv | 17 +
 rtl/audio_mod_chan.sv | 69 ++++++
 rtl/audio_pwm_mc.sv | 86 ++++++++
 tb/tb_audio_pwm_mc.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the multi-channel audio DAC front end:
// output mode encodings, clamp floor and the midscale reset level.
package audio_pkg;

    typedef enum logic {
        MODE_PWM = 1'b0,
        MODE_DS  = 1'b1
    } mode_e;

    localparam int CLAMP_MIN = 1;

    // Midscale sample for a given width; used as the post-reset active level.
    function automatic int unsigned midscale(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/audio_mod_chan.sv
// One audio channel: clamps the latched sample, then drives either an
// edge-aligned PWM compare or a first-order delta-sigma modulator.
module audio_mod_chan
    import audio_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] counter_i,
    input  logic             latch_i,
    input  logic             load_i,
    input  mode_e            mode_i,
    input  logic [WIDTH-1:0] sample_i,
    input  logic             enable_i,
    output logic             aud_o
);

    logic [WIDTH-1:0] v_q, v_d;
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH:0]   acc_sum;
    logic [WIDTH:0]   acc_base;
    logic [WIDTH-1:0] acc_d;
    logic             aud_q, aud_d;
    logic [WIDTH-1:0] clamped;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        clamped  = (sample_i < WIDTH'(CLAMP_MIN)) ? WIDTH'(CLAMP_MIN) : sample_i;
        v_d      = v_q;
        mode_d   = mode_q;
        if (latch_i) begin
            mode_d = mode_i;
            if (load_i) v_d = clamped;
        end
        // The new frame's level and mode already apply on the latch cycle itself.
        acc_base = (latch_i && (mode_d != mode_q)) ? '0 : {1'b0, acc_q};
        acc_sum  = acc_base + {1'b0, v_d};
        acc_d    = '0;
        aud_d    = 1'b0;
        if (enable_i) begin
            if (mode_d == MODE_DS) begin
                acc_d = acc_sum[WIDTH-1:0];
                aud_d = acc_sum[WIDTH];
            end else begin
                aud_d = (counter_i < v_d);
            end
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= WIDTH'(midscale(WIDTH));
            mode_q <= MODE_PWM;
            acc_q  <= '0;
            aud_q  <= 1'b0;
        end else begin
            v_q    <= v_d;
            mode_q <= mode_d;
            acc_q  <= acc_d;
            aud_q  <= aud_d;
        end
    end

    assign aud_o = aud_q;

endmodule

// File: rtl/audio_pwm_mc.sv
// Multi-channel audio DAC front end: frame counter, one-frame holding
// buffer with valid/ready intake, underrun flag and per-channel modulators.
module audio_pwm_mc
    import audio_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      mode,
    input  logic [CHANNELS*WIDTH-1:0] sample_in,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    output logic                      frame_start,
    output logic                      underrun,
    input  logic                      underrun_clr,
    output logic [CHANNELS-1:0]       aud_out,
    output logic                      aud_sd
);

    logic [WIDTH-1:0]          cnt_q, cnt_d;
    logic                      buf_full_q, buf_full_d;
    logic [CHANNELS*WIDTH-1:0] buf_q;
    logic                      underrun_q, underrun_d;
    logic                      frame_start_q;
    logic                      aud_sd_q;
    logic                      latch;
    logic                      xfer;
    logic                      load;

    assign latch = enable && (cnt_q == '0);
    assign xfer  = sample_valid && !buf_full_q;
    assign load  = latch && buf_full_q;

    always_comb begin
        cnt_d      = enable ? cnt_q + 1'b1 : '0;
        // A full buffer never accepts a transfer, so set and clear cannot collide.
        buf_full_d = xfer ? 1'b1 : (load ? 1'b0 : buf_full_q);
        underrun_d = underrun_q;
        if (latch && !buf_full_q) underrun_d = 1'b1;
        else if (underrun_clr)    underrun_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            buf_full_q    <= 1'b0;
            underrun_q    <= 1'b0;
            frame_start_q <= 1'b0;
            aud_sd_q      <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            buf_full_q    <= buf_full_d;
            underrun_q    <= underrun_d;
            frame_start_q <= latch;
            aud_sd_q      <= enable;
        end
    end

    // NOTE: the buffer payload needs no reset; it is only read while buf_full_q is set.
    always_ff @(posedge clk) begin
        if (xfer) buf_q <= sample_in;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        audio_mod_chan #(.WIDTH(WIDTH)) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .counter_i (cnt_q),
            .latch_i   (latch),
            .load_i    (load),
            .mode_i    (mode_e'(mode)),
            .sample_i  (buf_q[c*WIDTH +: WIDTH]),
            .enable_i  (enable),
            .aud_o     (aud_out[c])
        );
    end

    assign sample_ready = !buf_full_q;
    assign frame_start  = frame_start_q;
    assign underrun     = underrun_q;
    assign aud_sd       = aud_sd_q;

endmodule

// File: tb/tb_audio_pwm_mc.sv
// Self-checking bench for audio_pwm_mc: directed frame measurements plus a
// randomized run, all compared against a behavioural frame-level model.
module tb_audio_pwm_mc;

    localparam int CH = 2;
    localparam int W  = 8;
    localparam int FR = 1 << W;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            enable = 1'b0;
    logic            mode = 1'b0;
    logic [CH*W-1:0] sample_in = '0;
    logic            sample_valid = 1'b0;
    logic            sample_ready;
    logic            frame_start;
    logic            underrun;
    logic            underrun_clr = 1'b0;
    logic [CH-1:0]   aud_out;
    logic            aud_sd;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    int m_cnt;
    bit m_full;
    int m_buf [CH];
    int m_v   [CH];
    int m_acc [CH];
    bit m_out [CH];
    bit m_mode, m_fs, m_ur, m_sd;

    audio_pwm_mc #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .mode         (mode),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .frame_start  (frame_start),
        .underrun     (underrun),
        .underrun_clr (underrun_clr),
        .aud_out      (aud_out),
        .aud_sd       (aud_sd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clampv(input int s);
        return (s < 1) ? 1 : ((s > FR - 1) ? FR - 1 : s);
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_full = 0; m_mode = 0; m_fs = 0; m_ur = 0; m_sd = 0;
        for (int c = 0; c < CH; c++) begin
            m_v[c] = FR / 2; m_acc[c] = 0; m_out[c] = 0; m_buf[c] = 0;
        end
    endtask

    task automatic model_step();
        bit full0, xfer, latch;
        if (!rst_n) begin
            model_reset();
            return;
        end
        full0 = m_full;
        xfer  = sample_valid && !full0;
        if (!enable) begin
            m_cnt = 0; m_fs = 0; m_sd = 0;
            for (int c = 0; c < CH; c++) begin m_out[c] = 0; m_acc[c] = 0; end
            if (underrun_clr) m_ur = 0;
        end else begin
            latch = (m_cnt == 0);
            m_fs  = latch;
            if (latch) begin
                if (full0) begin
                    for (int c = 0; c < CH; c++) m_v[c] = clampv(m_buf[c]);
                    m_full = 0;
                end
                if (mode != m_mode)
                    for (int c = 0; c < CH; c++) m_acc[c] = 0;
                m_mode = mode;
            end
            if (latch && !full0) m_ur = 1;
            else if (underrun_clr) m_ur = 0;
            for (int c = 0; c < CH; c++) begin
                if (m_mode) begin
                    m_acc[c] = (m_acc[c] % FR) + m_v[c];
                    m_out[c] = (m_acc[c] >= FR);
                end else begin
                    m_out[c] = (m_cnt < m_v[c]);
                end
            end
            m_cnt = (m_cnt + 1) % FR;
            m_sd  = 1;
        end
        if (xfer) begin
            m_full = 1;
            for (int c = 0; c < CH; c++) m_buf[c] = int'(sample_in[c*W +: W]);
        end
    endtask

    task automatic compare_all();
        logic [CH-1:0] eo;
        for (int c = 0; c < CH; c++) eo[c] = m_out[c];
        check("aud_out", 32'(aud_out), 32'(eo));
        check("sample_ready", 32'(sample_ready), 32'(!m_full));
        check("frame_start", 32'(frame_start), 32'(m_fs));
        check("underrun", 32'(underrun), 32'(m_ur));
        check("aud_sd", 32'(aud_sd), 32'(m_sd));
    endtask

    // Inputs are driven at the negedge; the model samples them at the posedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic push(input logic [CH*W-1:0] s);
        sample_in    = s;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    // Counts output highs over one frame, starting at the frame_start sample.
    task automatic measure_frame(output int hi0, output int hi1, output int tog1);
        int  n = 0;
        logic prev;
        while (!frame_start && n < 3 * FR) begin tick(); n++; end
        check("frame_seen", 32'(frame_start), 32'd1);
        hi0  = int'(aud_out[0]);
        hi1  = int'(aud_out[1]);
        prev = aud_out[1];
        tog1 = 0;
        for (int i = 1; i < FR; i++) begin
            tick();
            hi0 += int'(aud_out[0]);
            hi1 += int'(aud_out[1]);
            if (aud_out[1] != prev) tog1++;
            prev = aud_out[1];
        end
    endtask

    task automatic run_to_latch();
        int n = 0;
        while (m_cnt != 0 && n < 2 * FR) begin tick(); n++; end
        check("latch_reached", 32'(m_cnt), 32'd0);
    endtask

    initial begin
        int h0, h1, tg;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        check("rst_aud_out", 32'(aud_out), 32'd0);
        check("rst_ready", 32'(sample_ready), 32'd1);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_aud_sd", 32'(aud_sd), 32'd0);

        // First frame runs at midscale with an underrun
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        measure_frame(h0, h1, tg);
        check("mid_hi0", 32'(h0), 32'd128);
        check("mid_hi1", 32'(h1), 32'd128);
        check("mid_underrun", 32'(underrun), 32'd1);
        check("mid_ready", 32'(sample_ready), 32'd1);

        // Mid-frame push, PWM
        repeat (10) tick();
        push({8'hC0, 8'h40});
        check("ready_drop", 32'(sample_ready), 32'd0);
        measure_frame(h0, h1, tg);
        check("pwm_hi0", 32'(h0), 32'd64);
        check("pwm_hi1", 32'(h1), 32'd192);
        check("ready_after_latch", 32'(sample_ready), 32'd1);

        // Clamp boundaries
        repeat (5) tick();
        push({8'hFF, 8'h00});
        measure_frame(h0, h1, tg);
        check("clamp_lo", 32'(h0), 32'd1);
        check("clamp_hi", 32'(h1), 32'd255);

        // Delta-sigma
        repeat (5) tick();
        mode = 1'b1;
        push({8'h80, 8'h01});
        measure_frame(h0, h1, tg);
        check("ds_ones_01", 32'(h0), 32'd1);
        check("ds_ones_80", 32'(h1), 32'd128);
        check("ds_toggle_80", 32'(tg), 32'd255);

        // Push in the latch cycle with the buffer empty
        run_to_latch();
        mode = 1'b0;
        push({8'h50, 8'h30});
        check("ur_latch_push", 32'(underrun), 32'd1);
        check("ur_latch_ready", 32'(sample_ready), 32'd0);
        measure_frame(h0, h1, tg);
        check("old_hi0", 32'(h0), 32'd1);
        check("old_hi1", 32'(h1), 32'd128);
        tick();
        repeat (3) tick();
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check("ur_clr", 32'(underrun), 32'd0);
        run_to_latch();
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check("ur_set_wins", 32'(underrun), 32'd1);
        measure_frame(h0, h1, tg);
        check("new_hi0", 32'(h0), 32'd48);
        check("new_hi1", 32'(h1), 32'd80);

        // Disable mid-frame, fill buffer while idle, then async reset
        repeat (20) tick();
        enable = 1'b0;
        tick();
        check("dis_aud_out", 32'(aud_out), 32'd0);
        check("dis_aud_sd", 32'(aud_sd), 32'd0);
        push({8'h11, 8'h22});
        check("dis_ready", 32'(sample_ready), 32'd0);
        enable = 1'b1;
        repeat (40) tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_aud_out", 32'(aud_out), 32'd0);
        check("arst_aud_sd", 32'(aud_sd), 32'd0);
        check("arst_ready", 32'(sample_ready), 32'd1);
        check("arst_fs", 32'(frame_start), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();
        check("reen_fs", 32'(frame_start), 32'd1);
        check("reen_aud_sd", 32'(aud_sd), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            sample_valid = ($urandom_range(0, 99) < 3);
            sample_in    = CH*W'($urandom);
            underrun_clr = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 999) < 3) mode = ~mode;
            if (enable) begin
                if ($urandom_range(0, 999) < 3) enable = 1'b0;
            end else if ($urandom_range(0, 99) < 10) begin
                enable = 1'b1;
            end
            tick();
        end
        sample_valid = 1'b0;
        underrun_clr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
